// File: rtl/gcd_client.sv
// gcd_client: initiator-side sequencer for the subtractive GCD core.
// Accepts an operand pair, loads it into the core (start+A, then B),
// waits for done with a bounded timeout and returns the result downstream.
// Pairs with a zero operand are answered locally since the core would hang.
module gcd_client #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         core_start,
  output logic [W-1:0] core_din,
  input  logic         core_done,
  input  logic [W-1:0] core_dout,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last counter value before the timeout fires: the counter holds k-1 in WAIT cycle k.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           out_valid_reg, out_valid_next;
  logic [W-1:0]   out_gcd_reg, out_gcd_next;
  logic           out_err_reg, out_err_next;
  logic           core_start_reg, core_start_next;
  logic [W-1:0]   core_din_reg, core_din_next;

  // State register and registered outputs; reset returns everything to IDLE/zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_gcd_reg    <= '0;
      out_err_reg    <= 1'b0;
      core_start_reg <= 1'b0;
      core_din_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      cnt_reg        <= cnt_next;
      out_valid_reg  <= out_valid_next;
      out_gcd_reg    <= out_gcd_next;
      out_err_reg    <= out_err_next;
      core_start_reg <= core_start_next;
      core_din_reg   <= core_din_next;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so that they are registered in the state they belong to.
  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    cnt_next        = cnt_reg;
    out_valid_next  = out_valid_reg;
    out_gcd_next    = out_gcd_reg;
    out_err_next    = out_err_reg;
    core_start_next = 1'b0;
    core_din_next   = core_din_reg;

    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          a_next = in_a;
          b_next = in_b;
          if (in_a == '0 || in_b == '0) begin
            // gcd(x,0)=x and gcd(0,0)=0, both equal to a|b.
            out_gcd_next   = in_a | in_b;
            out_err_next   = 1'b0;
            out_valid_next = 1'b1;
            state_next     = S_RESP;
          end else begin
            core_start_next = 1'b1;
            core_din_next   = in_a;
            state_next      = S_SEND_A;
          end
        end
      end
      S_SEND_A: begin
        core_din_next = b_reg;
        state_next    = S_SEND_B;
      end
      S_SEND_B: begin
        core_din_next = '0;
        cnt_next      = '0;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          // A done in the last allowed cycle still wins over the timeout.
          out_gcd_next   = core_dout;
          out_err_next   = 1'b0;
          out_valid_next = 1'b1;
          state_next     = S_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            out_gcd_next   = '0;
            out_err_next   = 1'b1;
            out_valid_next = 1'b1;
            state_next     = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign in_ready   = (state_reg == S_IDLE) && !rst;
  assign busy       = (state_reg != S_IDLE);
  assign out_valid  = out_valid_reg;
  assign out_gcd    = out_gcd_reg;
  assign out_err    = out_err_reg;
  assign core_start = core_start_reg;
  assign core_din   = core_din_reg;

endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: scoreboard bench for gcd_client. Two instances are used:
// a long-timeout one for the 20-cycle core latency case and a TIMEOUT=8 one
// for the timeout, boundary, bypass, backpressure and reset cases.
module tb_gcd_client;

  localparam int W   = 16;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;   // 0: short-timeout instance, 1: long-timeout instance
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_ready = 1'b1;
  logic         core_done = 1'b0;
  logic [W-1:0] core_dout = '0;

  logic         s_in_ready, s_out_valid, s_out_err, s_core_start, s_busy;
  logic [W-1:0] s_out_gcd, s_core_din;
  logic         l_in_ready, l_out_valid, l_out_err, l_core_start, l_busy;
  logic [W-1:0] l_out_gcd, l_core_din;

  logic         in_ready, out_valid, out_err, core_start, busy;
  logic [W-1:0] out_gcd, core_din;

  int checks = 0;
  int failures = 0;
  logic [W:0] sb_q[$];   // {err, gcd}

  always #5 clk = ~clk;

  gcd_client #(.W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_gcd(s_out_gcd), .out_err(s_out_err),
    .core_start(s_core_start), .core_din(s_core_din),
    .core_done(core_done && !sel), .core_dout(core_dout), .busy(s_busy)
  );

  gcd_client #(.W(W), .TIMEOUT(1023)) dut_long (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel), .in_ready(l_in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_gcd(l_out_gcd), .out_err(l_out_err),
    .core_start(l_core_start), .core_din(l_core_din),
    .core_done(core_done && sel), .core_dout(core_dout), .busy(l_busy)
  );

  assign in_ready   = sel ? l_in_ready   : s_in_ready;
  assign out_valid  = sel ? l_out_valid  : s_out_valid;
  assign out_err    = sel ? l_out_err    : s_out_err;
  assign core_start = sel ? l_core_start : s_core_start;
  assign busy       = sel ? l_busy       : s_busy;
  assign out_gcd    = sel ? l_out_gcd    : s_out_gcd;
  assign core_din   = sel ? l_core_din   : s_core_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: a result handshake is compared against the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        check("sb_gcd", 32'(out_gcd), 32'(e[W-1:0]));
        check("sb_err", 32'(out_err), 32'(e[W]));
        $display("result gcd=%0d err=%0d", out_gcd, out_err);
      end
    end
  end

  // Core-path transaction; returns at the negedge of the first RESP cycle.
  task automatic send_core(input logic [W-1:0] a, input logic [W-1:0] b, input int done_k,
                           input logic [W-1:0] dout, input logic [W-1:0] exp_gcd,
                           input logic exp_err);
    int limit;
    limit = (done_k > 0) ? done_k : TMO;
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    sb_q.push_back({exp_err, exp_gcd});
    $display("send a=%0d b=%0d expect gcd=%0d err=%0d", a, b, exp_gcd, exp_err);
    @(negedge clk);
    in_valid = 1'b0;
    check("send_a_start", 32'(core_start), 1);
    check("send_a_din", 32'(core_din), 32'(a));
    @(negedge clk);
    check("send_b_start", 32'(core_start), 0);
    check("send_b_din", 32'(core_din), 32'(b));
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      check("wait_no_valid", 32'(out_valid), 0);
      if (k == 1) check("wait_din", 32'(core_din), 0);
      core_done = (k == done_k);
      core_dout = (k == done_k) ? dout : '0;
    end
    @(negedge clk);
    core_done = 1'b0;
    check("resp_valid", 32'(out_valid), 1);
    check("resp_err", 32'(out_err), 32'(exp_err));
  endtask

  // Zero-operand pair resolved locally.
  task automatic send_bypass(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("byp_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    sb_q.push_back({1'b0, a | b});
    $display("bypass a=%0d b=%0d", a, b);
    @(negedge clk);
    in_valid = 1'b0;
    check("byp_valid", 32'(out_valid), 1);
    check("byp_no_start", 32'(core_start), 0);
    @(negedge clk);
    check("byp_done_valid", 32'(out_valid), 0);
    check("byp_no_start2", 32'(core_start), 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_after", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_out_gcd", 32'(out_gcd), 0);

    // Normal pair with 20-cycle core latency on the long-timeout instance
    sel = 1'b1;
    send_core(16'd48, 16'd18, 20, 16'd6, 16'd6, 1'b0);
    @(negedge clk);
    check("norm_released", 32'(out_valid), 0);
    check("norm_idle_ready", 32'(in_ready), 1);
    sel = 1'b0;

    // Zero bypass
    send_bypass(16'd0, 16'd35);
    send_bypass(16'd0, 16'd0);

    // Timeout, then a stray done, then a normal pair
    send_core(16'd48, 16'd18, 0, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    core_done = 1'b1; core_dout = 16'd99;
    check("tmo_idle", 32'(busy), 0);
    @(negedge clk);
    core_done = 1'b0;
    check("stray_no_valid", 32'(out_valid), 0);
    check("stray_busy", 32'(busy), 0);
    send_core(16'd9, 16'd6, 4, 16'd3, 16'd3, 1'b0);
    @(negedge clk);

    // Done exactly in the last WAIT cycle
    send_core(16'd35, 16'd14, TMO, 16'd7, 16'd7, 1'b0);
    @(negedge clk);

    // Backpressure with next pair held on the input
    out_ready = 1'b0;
    send_core(16'd21, 16'd14, 3, 16'd7, 16'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'd21; in_b = 16'd14;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_gcd", 32'(out_gcd), 7);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("bp_in_ready_hs", 32'(in_ready), 0);
    send_core(16'd21, 16'd14, 2, 16'd7, 16'd7, 1'b0);
    @(negedge clk);

    // Reset mid-WAIT; the later done must be ignored
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_valid", 32'(out_valid), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_gcd", 32'(out_gcd), 0);
    check("rstw_err", 32'(out_err), 0);
    check("rstw_din", 32'(core_din), 0);
    check("rstw_start", 32'(core_start), 0);
    @(negedge clk);
    core_done = 1'b1; core_dout = 16'd6;
    check("rstw_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    core_done = 1'b0;
    check("rstw_stray_valid", 32'(out_valid), 0);
    check("rstw_stray_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    check("rstw_quiet", 32'(out_valid), 0);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
